// File: rtl/parking_pkg.sv
// parking_pkg
//   Shared types and constants for the parking gate arbiter.
//   - state_t       : transaction FSM states
//   - MAX_SPACES_DEF: default lot capacity (must match parking_ctrl)
//   - open_cnt_w()  : width of the barrier-open down-counter
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OPEN  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam int unsigned MAX_SPACES_DEF = 20;

    // Counter must hold OPEN_CYCLES-1; keep at least one bit.
    function automatic int unsigned open_cnt_w(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr and moves
//   toward higher indices, wrapping at W.
//   Ports:
//     req   in  W  : masked request vector
//     ptr   in  IW : search start index (must be < W)
//     grant out W  : one-hot grant (all zero when req is zero)
//     idx   out IW : index of the granted bit
module rr_arbiter #(
    parameter int unsigned W  = 4,
    parameter int unsigned IW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  grant,
    output logic [IW-1:0] idx
);

    localparam int unsigned SW = IW + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(W)) begin
                sum = sum - SW'(W);
            end
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Serialises entry/exit barrier gates onto one parking_ctrl occupancy
//   counter. One transaction at a time: IDLE -> GRANT -> OPEN -> CLEAR.
//   Build option: define PARK_EXIT_PRIORITY_EN to let any unmasked exit
//   request beat all entry requests (round-robin within each class).
//   Ports:
//     clk, rst      : clock (rising edge), async active-high reset
//     entry_req     : level request per entry gate
//     exit_req      : level request per exit gate
//     count, full   : occupancy and full flag from parking_ctrl
//     entry_pulse   : one-cycle increment strobe
//     exit_pulse    : one-cycle decrement strobe
//     gate_open     : one-hot barrier open, entries low bits, exits high
//     busy          : FSM not in IDLE
//     entry_denied  : one-cycle pulse when an entry is refused (lot full)
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned N_ENTRY     = 2,
    parameter int unsigned N_EXIT      = 2,
    parameter int unsigned MAX_SPACES  = MAX_SPACES_DEF,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned OPEN_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ENTRY-1:0]        entry_req,
    input  logic [N_EXIT-1:0]         exit_req,
    input  logic [CNT_W-1:0]          count,
    input  logic                      full,
    output logic                      entry_pulse,
    output logic                      exit_pulse,
    output logic [N_ENTRY+N_EXIT-1:0] gate_open,
    output logic                      busy,
    output logic                      entry_denied
);

    localparam int unsigned W  = N_ENTRY + N_EXIT;
    localparam int unsigned IW = $clog2(W);
    localparam int unsigned TW = open_cnt_w(OPEN_CYCLES);
    localparam logic [TW-1:0] T_LOAD = TW'(OPEN_CYCLES - 1);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [W-1:0]  win_oh;
    logic [TW-1:0] timer;
    logic          armed;

    logic               lot_full;
    logic               lot_empty;
    logic [N_ENTRY-1:0] masked_entry;
    logic [N_EXIT-1:0]  masked_exit;
    logic [W-1:0]       req_raw;
    logic [W-1:0]       arb_req;
    logic [W-1:0]       arb_grant;
    logic [IW-1:0]      arb_idx;

    // The count comparison is redundant with full when parking_ctrl is
    // sized correctly; it keeps entries blocked if the flag lags.
    assign lot_full     = full | (count >= CNT_W'(MAX_SPACES));
    assign lot_empty    = (count == '0);
    assign masked_entry = lot_full  ? '0 : entry_req;
    assign masked_exit  = lot_empty ? '0 : exit_req;
    assign req_raw      = {exit_req, entry_req};

`ifdef PARK_EXIT_PRIORITY_EN
    assign arb_req = (|masked_exit) ? {masked_exit, {N_ENTRY{1'b0}}}
                                    : {masked_exit, masked_entry};
`else
    assign arb_req = {masked_exit, masked_entry};
`endif

    rr_arbiter #(
        .W  (W),
        .IW (IW)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            winner       <= '0;
            win_oh       <= '0;
            timer        <= '0;
            armed        <= 1'b1;
            entry_denied <= 1'b0;
        end else begin
            entry_denied <= 1'b0;
            if (entry_req == '0) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|arb_req) begin
                        state  <= GRANT;
                        winner <= arb_idx;
                        win_oh <= arb_grant;
                        timer  <= T_LOAD;
                    end else if (lot_full && (|entry_req) && (exit_req == '0) && armed) begin
                        entry_denied <= 1'b1;
                        armed        <= 1'b0;
                    end
                end
                GRANT: begin
                    ptr   <= (winner == IW'(W - 1)) ? '0 : winner + IW'(1);
                    timer <= timer - TW'(1);
                    state <= OPEN;
                end
                OPEN: begin
                    // Timer starts at OPEN_CYCLES-1 in GRANT, so GRANT plus
                    // OPEN spans exactly OPEN_CYCLES cycles.
                    if (timer == '0) begin
                        state <= CLEAR;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                CLEAR: begin
                    if (!(|(req_raw & win_oh))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign gate_open   = ((state == GRANT) || (state == OPEN)) ? win_oh : '0;
    assign entry_pulse = (state == GRANT) && (|win_oh[N_ENTRY-1:0]);
    assign exit_pulse  = (state == GRANT) && (|win_oh[W-1:N_ENTRY]);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter
//   Directed bench with a transaction-level reference model (cycles since
//   grant, integer pointer) compared against the DUT every cycle.
module tb_parking_gate_arbiter;

    localparam int NE = 2;
    localparam int NX = 2;
    localparam int W  = NE + NX;
    localparam int OC = 8;
    localparam int MS = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [NE-1:0] entry_req = '0;
    logic [NX-1:0] exit_req  = '0;
    logic [5:0]   count = '0;
    logic         full  = 1'b0;
    logic         entry_pulse;
    logic         exit_pulse;
    logic [W-1:0] gate_open;
    logic         busy;
    logic         entry_denied;

    int total = 0;
    int bad   = 0;

    parking_gate_arbiter #(
        .N_ENTRY     (NE),
        .N_EXIT      (NX),
        .MAX_SPACES  (MS),
        .CNT_W       (6),
        .OPEN_CYCLES (OC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .count        (count),
        .full         (full),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .gate_open    (gate_open),
        .busy         (busy),
        .entry_denied (entry_denied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy;
    int m_win;
    int m_k;      // cycles since grant; >= OC means barrier closed
    int m_ptr;
    bit m_armed;
    bit m_denied;

    function automatic bit req_bit(input int g);
        logic [W-1:0] r;
        r = {exit_req, entry_req};
        return r[g];
    endfunction

    function automatic bit eligible(input int g);
        if (g < NE) return req_bit(g) && !full;
        return req_bit(g) && (count != 0);
    endfunction

    task automatic model_step();
        int pick;
        bit any_exit;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_armed = 1; m_denied = 0; m_k = 0; m_win = 0;
            return;
        end
        m_denied = 0;
        if (!m_busy) begin
            pick = -1;
            any_exit = 0;
`ifdef PARK_EXIT_PRIORITY_EN
            for (int g = NE; g < W; g++) if (eligible(g)) any_exit = 1;
`endif
            for (int i = 0; i < W; i++) begin
                int g;
                g = (m_ptr + i) % W;
                if (pick < 0 && eligible(g) && !(any_exit && g < NE)) pick = g;
            end
            if (pick >= 0) begin
                m_busy = 1; m_win = pick; m_k = 0; m_ptr = (pick + 1) % W;
            end else if (full && entry_req != 0 && exit_req == 0 && m_armed) begin
                m_denied = 1; m_armed = 0;
            end
        end else begin
            if (m_k >= OC && !req_bit(m_win)) m_busy = 0;
            else if (m_k < OC) m_k++;
        end
        if (entry_req == 0) m_armed = 1;
    endtask

    task automatic compare_outputs();
        int exp_go;
        exp_go = (m_busy && m_k < OC) ? (1 << m_win) : 0;
        chk("busy", int'(busy), int'(m_busy));
        chk("gate_open", int'(gate_open), exp_go);
        chk("entry_pulse", int'(entry_pulse), int'(m_busy && m_k == 0 && m_win < NE));
        chk("exit_pulse", int'(exit_pulse), int'(m_busy && m_k == 0 && m_win >= NE));
        chk("entry_denied", int'(entry_denied), int'(m_denied));
        chk("pulse_exclusive", int'(entry_pulse && exit_pulse), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare_outputs();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int g, input logic v);
        if (g < NE) entry_req[g] = v;
        else        exit_req[g - NE] = v;
    endtask

    task automatic wait_open(output int g);
        g = -1;
        for (int c = 0; c < 60 && g < 0; c++) begin
            @(posedge clk); #1;
            for (int b = W - 1; b >= 0; b--) if (gate_open[b]) g = b;
        end
        if (g < 0) chk("wait_open_timeout", 0, 1);
    endtask

    // Waits for a grant, checks its pulse, drops the winner's request in
    // the first closed cycle and optionally raises it again.
    task automatic serve_once(input bit rearm, output int g);
        bit closed;
        wait_open(g);
        if (g < 0) return;
        if (g < NE) chk("grant_entry_pulse", int'(entry_pulse), 1);
        else        chk("grant_exit_pulse", int'(exit_pulse), 1);
        closed = 0;
        for (int c = 0; c < 20 && !closed; c++) begin
            @(posedge clk); #1;
            if (gate_open == 0) closed = 1;
        end
        if (!closed) chk("close_timeout", 0, 1);
        @(negedge clk); set_req(g, 1'b0);
        if (rearm) begin
            @(negedge clk); set_req(g, 1'b1);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int c = 0; c < 40 && !idle; c++) begin
            @(posedge clk); #1;
            if (!busy) idle = 1;
        end
        chk("wait_idle", int'(idle), 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int g, g2, n_open, n_pulse, n_den, n_busy;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_gate_open", int'(gate_open), 0);
        chk("reset_pulses", int'(entry_pulse | exit_pulse | entry_denied), 0);

        // Single entry at empty lot.
        @(negedge clk); count = 0; full = 0; entry_req = 2'b01;
        n_open = 0; n_pulse = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk("single_pulse_latency", int'(entry_pulse), 1);
            if (gate_open == 4'b0001) n_open++;
            if (entry_pulse) n_pulse++;
        end
        chk("single_open_cycles", n_open, 8);
        chk("single_pulse_count", n_pulse, 1);
        chk("single_busy_held", int'(busy), 1);
        @(negedge clk); entry_req = 2'b00;
        @(posedge clk); #1;
        chk("single_busy_release", int'(busy), 0);

        // Fairness between two entry gates.
        do_reset();
        count = 5; full = 0; entry_req = 2'b11;
        serve_once(1, g);  chk("fair_1st", g, 0);
        serve_once(1, g);  chk("fair_2nd", g, 1);
        serve_once(0, g);  chk("fair_3rd", g, 0);
        @(negedge clk); entry_req = 2'b00;
        wait_idle();

        // Full lot: entry denied once, exit still served.
        @(negedge clk); count = 20; full = 1; entry_req = 2'b10;
        n_den = 0; n_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (entry_denied) n_den++;
            if (busy) n_busy++;
        end
        chk("full_denied_once", n_den, 1);
        chk("full_no_grant", n_busy, 0);
        @(negedge clk); exit_req = 2'b01;
        serve_once(0, g);
        chk("full_exit_gate", g, 2);
        n_den = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (entry_denied) n_den++;
        end
        chk("full_no_rearm", n_den, 0);
        @(negedge clk); entry_req = 2'b00;
        wait_idle();

        // Empty lot: exits are blocked.
        @(negedge clk); count = 0; full = 0; exit_req = 2'b11;
        n_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (busy || exit_pulse) n_busy++;
        end
        chk("empty_no_grant", n_busy, 0);
        @(negedge clk); exit_req = 2'b00;

        // Simultaneous entry and exit with pointer at 0.
        do_reset();
        count = 5; full = 0; entry_req = 2'b01; exit_req = 2'b10;
        serve_once(0, g);
        serve_once(0, g2);
`ifdef PARK_EXIT_PRIORITY_EN
        chk("simul_first", g, 3);
        chk("simul_second", g2, 0);
`else
        chk("simul_first", g, 0);
        chk("simul_second", g2, 3);
`endif
        wait_idle();

        // Reset in the third OPEN cycle.
        @(negedge clk); count = 5; full = 0; entry_req = 2'b01;
        wait_open(g);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_gate_open", int'(gate_open), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pulses", int'(entry_pulse | exit_pulse | entry_denied), 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_regrant_pulse", int'(entry_pulse), 1);
        chk("midrst_regrant_gate", int'(gate_open), 1);
        @(negedge clk); entry_req = 2'b00;
        wait_idle();

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single `parking_ctrl` occupancy counter among several entry and exit barrier gates. It serialises gate transactions through one FSM with a round-robin arbiter, and drives the counter's `entry_pulse`/`exit_pulse` exactly once per admitted vehicle. It blocks entries while the lot is full and exits while it is empty, and it times each barrier-open window. The block sits between the gate sensor front-ends and `parking_ctrl`.

## Interface
- `N_ENTRY`, 2: number of entry gates (1..4)
- `N_EXIT`, 2: number of exit gates (1..4)
- `MAX_SPACES`, 20: lot capacity; must equal the counter's `MAX_SPACES`
- `CNT_W`, 6: width of `count`; must satisfy 2^CNT_W > MAX_SPACES
- `OPEN_CYCLES`, 8: barrier-open hold time in clk cycles (≥2)

- `clk`  in  1: system clock, rising edge
- `rst`  in  1: asynchronous, active-high reset
- `entry_req`  in  N_ENTRY: level request per entry gate; held high until the vehicle has passed
- `exit_req`  in  N_EXIT: level request per exit gate; same rule as `entry_req`
- `count`  in  CNT_W: occupancy from `parking_ctrl`
- `full`  in  1: full flag from `parking_ctrl`
- `entry_pulse`  out  1: one-cycle increment strobe to `parking_ctrl`
- `exit_pulse`  out  1: one-cycle decrement strobe to `parking_ctrl`
- `gate_open`  out  N_ENTRY+N_EXIT: one-hot barrier-open; bits [N_ENTRY-1:0] are entries, upper bits are exits
- `busy`  out  1: FSM not in IDLE
- `entry_denied`  out  1: one-cycle pulse when an entry is blocked because the lot is full

## Operation
- Request vector: `req = {exit_req, entry_req}`.
  - Entry bits are masked when `full`=1.
  - Exit bits are masked when `count`=0.
- FSM states are IDLE, GRANT, OPEN and CLEAR.
  - **IDLE:** if the masked `req` is nonzero, the round-robin arbiter picks the winner and the FSM goes to GRANT. Otherwise it stays in IDLE.
  - **GRANT (1 cycle):** the winner index is registered; `gate_open[winner]`=1; `entry_pulse` or `exit_pulse`=1 according to gate type. Next state is OPEN.
  - **OPEN:** `gate_open[winner]` is held; a down-counter runs from OPEN_CYCLES-1 to 0, then the FSM goes to CLEAR.
  - **CLEAR:** `gate_open`=0; the FSM waits for the winner's `req` bit to go low, then returns to IDLE.
- Round-robin pointer:
  - Updated on GRANT to winner+1, mod N_ENTRY+N_EXIT.
  - Search starts at the pointer and moves toward higher indices, wrapping around.
- `entry_denied` pulses in IDLE when `full`=1, an entry request is pending and no exit request is pending.
  - It re-arms only after all `entry_req` bits are low.
- Only one transaction is in flight at a time. `entry_pulse` and `exit_pulse` are never high in the same cycle.
- A winner's `req` dropping during GRANT or OPEN does not abort the transaction; the pulse has already been issued.

## Timing
- Reset values: state IDLE, pointer 0, every output 0.
- Reset mid-transaction returns to IDLE immediately. A pulse cut short by reset is not reissued.
- Request seen in IDLE at edge *n*: GRANT pulse and `gate_open` are high in cycle *n+1*.
- `gate_open` stays high for exactly OPEN_CYCLES cycles, GRANT cycle included.
- Earliest next GRANT: OPEN_CYCLES+2 cycles after the previous one, once the request has dropped at the first CLEAR cycle.
  - The counter updates one cycle after the pulse, so `full` and `count` are settled before the next IDLE sample.
- Simultaneous entry and exit requests: arbitration follows the pointer; the loser is served in a later transaction.
- At capacity (`count`=MAX_SPACES) only exits win. At `count`=0 only entries win.

## Configuration
- `PARK_EXIT_PRIORITY_EN`
  - **Defined:** any unmasked exit request beats all entry requests. Round-robin applies within each class.
  - **Undefined:** a single round-robin over all N_ENTRY+N_EXIT requesters.

## Structure
- `parking_pkg` holds:
  - the state enum (IDLE/GRANT/OPEN/CLEAR);
  - the `MAX_SPACES` default constant;
  - a function giving the open-counter width.
- One sub-module: `rr_arbiter`. It is parameterised on request width; its inputs are the masked request and the pointer, its outputs are the one-hot grant and the index.
- The FSM and timer live in the top module.

## Test plan
- **Reset then single entry:** `entry_req[0]` high with count=0 → one `entry_pulse`, one cycle after the request; `gate_open`=0b0001 for 8 cycles; `busy` returns low after `entry_req` drops.
- **Fairness:** `entry_req`=2'b11 held with count<MAX → grants alternate gate0, gate1, gate0; exactly one pulse per grant.
- **Full lot:** count=20, `full`=1, `entry_req[1]` high → no `entry_pulse`, one `entry_denied` pulse. Then assert `exit_req[0]` → `exit_pulse`, and `gate_open`=0b0100.
- **Empty lot:** count=0, only `exit_req` high → no pulse, `busy`=0.
- **Simultaneous requests:** `entry_req[0]` and `exit_req[1]` rise in the same cycle with pointer=0 → the entry is granted first and the exit second; pulses are never coincident. With `PARK_EXIT_PRIORITY_EN` the exit is granted first.
- **Reset mid-OPEN:** assert `rst` in cycle 3 of OPEN → all outputs 0 immediately; the FSM restarts from IDLE.
